nios_system_debounced_pio: RTL and testbench

NIOS_SYSTEM_DEBOUNCED_PIO -- requirements
Module: nios_system_debounced_pio

---
 rtl/nios_system_debounced_pio.sv | 128 ++++++++++++
 tb/tb_nios_system_debounced_pio.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_debounced_pio.sv
// Avalon-MM PIO with per-channel input synchronisers and debounce counters.
// Edges of the debounced inputs are captured (rise/fall selectable) and can raise an interrupt.
module nios_system_debounced_pio #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync;
  logic [WIDTH-1:0]                  r_db;
  logic [WIDTH-1:0]                  w_upd;
  logic [CW-1:0]                     r_cnt     [WIDTH];
  logic [CW-1:0]                     w_cnt_nxt [WIDTH];

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_unused = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // A channel accepts its synchronised value only after it has differed from db
  // for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
  always_comb begin
    w_upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_sync[i] != r_db[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_upd[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_db <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_db <= r_db ^ w_upd;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_set = w_upd & ((w_sync & r_rise) | (~w_sync & r_fall));
  assign w_clr = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  // Set is ORed in after the clear so a simultaneous new edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_edge <= '0;
      r_rise <= '1;
      r_fall <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          3'd2:    r_mask <= writedata[WIDTH-1:0];
          3'd4:    r_rise <= writedata[WIDTH-1:0];
          3'd5:    r_fall <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  assign irq = |(r_edge & r_mask);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      3'd0:    w_rd_mux[WIDTH-1:0] = r_db;
      3'd1:    w_rd_mux[WIDTH-1:0] = w_sync;
      3'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
      3'd3:    w_rd_mux[WIDTH-1:0] = r_edge;
      3'd4:    w_rd_mux[WIDTH-1:0] = r_rise;
      3'd5:    w_rd_mux[WIDTH-1:0] = r_fall;
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

endmodule

// File: tb/tb_nios_system_debounced_pio.sv
// Directed bench for nios_system_debounced_pio with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
module tb_nios_system_debounced_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic        irq;
  logic [31:0] readdata;

  int n_vec;
  int n_err;

  nios_system_debounced_pio #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .irq(irq),
    .readdata(readdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        do_wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    in_port    = 4'h0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    reset_n    = 1'b0;
    tick(1);
    reset_n    = 1'b1;
  endtask

  logic [31:0] d;
  logic        irq_seen;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    in_port    = 4'h0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    vecs[0]  = '{1'b0, 3'd4, 32'h0,        32'h0000000F};
    vecs[1]  = '{1'b0, 3'd5, 32'h0,        32'h00000000};
    vecs[2]  = '{1'b0, 3'd2, 32'h0,        32'h00000000};
    vecs[3]  = '{1'b0, 3'd3, 32'h0,        32'h00000000};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,        32'h00000000};
    vecs[5]  = '{1'b0, 3'd1, 32'h0,        32'h00000000};
    vecs[6]  = '{1'b0, 3'd6, 32'h0,        32'h00000000};
    vecs[7]  = '{1'b0, 3'd7, 32'h0,        32'h00000000};
    vecs[8]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 32'h0000000F};
    vecs[9]  = '{1'b1, 3'd4, 32'h00000005, 32'h00000005};
    vecs[10] = '{1'b1, 3'd5, 32'h0000000A, 32'h0000000A};
    vecs[11] = '{1'b1, 3'd0, 32'h0000000F, 32'h00000000};
    vecs[12] = '{1'b1, 3'd1, 32'h0000000F, 32'h00000000};
    vecs[13] = '{1'b1, 3'd6, 32'h0000000F, 32'h00000000};
    vecs[14] = '{1'b1, 3'd7, 32'h0000000F, 32'h00000000};
    vecs[15] = '{1'b1, 3'd3, 32'h0000000F, 32'h00000000};
    vecs[16] = '{1'b1, 3'd2, 32'h00000000, 32'h00000000};

    // Reset values visible before any clock edge
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    tick(1);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end

    // RAW follows the synchroniser, DATA waits for debounce
    in_port = 4'h5;
    tick(3);
    rd(3'd1, d);
    check("raw_sync", d, 32'h5);
    rd(3'd0, d);
    check("raw_not_debounced", d, 32'h0);

    // Clean press with interrupt and write-1-to-clear
    do_reset();
    wr(3'd2, 32'h1);
    address = 3'd0;
    in_port = 4'h1;
    tick(9);
    check("press_irq_early", {31'h0, irq}, 32'h0);
    check("press_data_early", readdata, 32'h0);
    tick(1);
    check("press_irq", {31'h0, irq}, 32'h1);
    tick(1);
    check("press_data", readdata, 32'h1);
    rd(3'd3, d);
    check("press_capture", d, 32'h1);
    wr(3'd3, 32'h1);
    check("press_irq_cleared", {31'h0, irq}, 32'h0);
    rd(3'd3, d);
    check("press_capture_cleared", d, 32'h0);

    // Bouncing channel 1 never stays stable for 8 cycles
    do_reset();
    wr(3'd2, 32'h2);
    irq_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      in_port[1] = (((k / 3) % 2) == 0);
      tick(1);
      irq_seen = irq_seen | irq;
    end
    in_port = 4'h0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      irq_seen = irq_seen | irq;
    end
    check("bounce_irq", {31'h0, irq_seen}, 32'h0);
    rd(3'd0, d);
    check("bounce_data", d, 32'h0);
    rd(3'd3, d);
    check("bounce_capture", d, 32'h0);

    // Falling-edge-only capture on channel 2
    do_reset();
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h4);
    in_port = 4'h4;
    tick(20);
    rd(3'd3, d);
    check("fall_after_rise_capture", d, 32'h0);
    rd(3'd0, d);
    check("fall_after_rise_data", d, 32'h4);
    in_port = 4'h0;
    tick(12);
    rd(3'd3, d);
    check("fall_capture", d, 32'h4);
    rd(3'd0, d);
    check("fall_data", d, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd4, 32'hF);
    rd(3'd3, d);
    check("fall_capture_kept", d, 32'h4);
    wr(3'd3, 32'hB);
    rd(3'd3, d);
    check("fall_clear_other_bits", d, 32'h4);
    wr(3'd3, 32'h4);
    rd(3'd3, d);
    check("fall_clear_bit2", d, 32'h0);

    // Clear lands on the same edge the rising update sets the capture bit
    do_reset();
    in_port = 4'h1;
    tick(9);
    wr(3'd3, 32'h1);
    rd(3'd3, d);
    check("collision_set_wins", d, 32'h1);
    rd(3'd0, d);
    check("collision_data", d, 32'h1);

    // Reset in the middle of a debounce
    do_reset();
    wr(3'd2, 32'h1);
    in_port = 4'h1;
    tick(12);
    check("mid_pre_irq", {31'h0, irq}, 32'h1);
    in_port = 4'h0;
    tick(12);
    rd(3'd0, d);
    check("mid_pre_release", d, 32'h0);
    address = 3'd4;
    in_port = 4'h1;
    tick(7);
    check("mid_pre_readdata", readdata, 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_readdata", readdata, 32'h0);
    check("mid_reset_irq", {31'h0, irq}, 32'h0);
    address = 3'd0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(10);
    check("mid_after_data_early", readdata, 32'h0);
    tick(1);
    check("mid_after_data", readdata, 32'h1);
    rd(3'd3, d);
    check("mid_after_capture", d, 32'h1);
    rd(3'd2, d);
    check("mid_after_mask", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
